// File: rtl/scan_sequencer.sv
// scan_sequencer: time-multiplexes a 16-bit word over four digit slots with per-slot blanking and frame-aligned loads.
// Optional LEADING_ZERO_BLANK_EN suppresses digits above the highest nonzero nibble.
module scan_sequencer #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic        Load,
  input  logic [15:0] Data,
  output logic        Ack,
  output logic        DigEn,
  output logic [1:0]  DigSel,
  output logic [3:0]  Nibble,
  output logic        FrameTick
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_d;
  logic [15:0]   act_q, act_d, sh_q, sh_d;
  logic          pend_q, pend_d, en_d, ack_d, tick_d, bnd, last;
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0]    hi;
`endif
  always_comb begin
    last   = cnt_q == CW'(PRESCALE - 1);
    cnt_d  = (Run && !last) ? cnt_q + CW'(1) : '0;
    sel_d  = Run ? DigSel + {1'b0, last} : 2'd0;
    tick_d = Run && last && DigSel == 2'd3;
    // a halted scan treats every edge as a frame boundary so pending words still land
    bnd    = !Run || tick_d;
    ack_d  = bnd && pend_q;
    act_d  = ack_d ? sh_q : act_q;
    sh_d   = Load ? Data : sh_q;
    pend_d = Load || (pend_q && !ack_d);
`ifdef LEADING_ZERO_BLANK_EN
    hi     = |act_d[15:12] ? 2'd3 : |act_d[11:8] ? 2'd2 : |act_d[7:4] ? 2'd1 : 2'd0;
    en_d   = Run && int'(cnt_d) >= BLANK && sel_d <= hi;
`else
    en_d   = Run && int'(cnt_d) >= BLANK;
`endif
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      DigSel    <= 2'd0;
      DigEn     <= 1'b0;
      act_q     <= '0;
      sh_q      <= '0;
      pend_q    <= 1'b0;
      Ack       <= 1'b0;
      FrameTick <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      DigSel    <= sel_d;
      DigEn     <= en_d;
      act_q     <= act_d;
      sh_q      <= sh_d;
      pend_q    <= pend_d;
      Ack       <= ack_d;
      FrameTick <= tick_d;
    end
  end
  assign Nibble = act_q[{DigSel, 2'b00} +: 4];
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed plus randomized checks of scan_sequencer against a cycle-count reference model.
module tb_scan_sequencer;
  localparam int P = 8;
  localparam int B = 2;
  logic        Clk = 1'b0, Rst = 1'b1, Run = 1'b0, Load = 1'b0;
  logic [15:0] Data = '0;
  logic        Ack, DigEn, FrameTick;
  logic [1:0]  DigSel;
  logic [3:0]  Nibble;
  int          vectors = 0, miscompares = 0;
  int          n = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic        m_pend = 1'b0, e_ack = 1'b0, e_tick = 1'b0, e_en = 1'b0;
  int          e_sel = 0, e_cnt = 0;

  scan_sequencer #(.PRESCALE(P), .BLANK(B)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Load(Load), .Data(Data),
    .Ack(Ack), .DigEn(DigEn), .DigSel(DigSel), .Nibble(Nibble), .FrameTick(FrameTick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  function automatic int top_digit(input logic [15:0] w);
    for (int i = 3; i > 0; i--) if (((w >> (4 * i)) & 16'hF) != 0) return i;
    return 0;
  endfunction

  // one clock: drive away from the edge, advance the model, then compare
  task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic rs = 1'b0);
    logic bnd;
    @(negedge Clk);
    Run = r; Load = ld; Data = d; Rst = rs;
    @(posedge Clk);
    if (rs) begin
      n = 0; m_act = '0; m_sh = '0; m_pend = 0; e_ack = 0; e_tick = 0;
    end else begin
      if (r) begin n++; bnd = (n % (4 * P)) == 0; end
      else begin n = 0; bnd = 1'b1; end
      e_tick = r && bnd;
      e_ack  = bnd && m_pend;
      if (e_ack) begin m_act = m_sh; m_pend = 0; end
      if (ld) begin m_sh = d; m_pend = 1; end
    end
    e_cnt = n % P;
    e_sel = (n / P) % 4;
    e_en  = !rs && r && e_cnt >= B;
`ifdef LEADING_ZERO_BLANK_EN
    e_en  = e_en && e_sel <= top_digit(m_act);
`endif
    #1;
    check("DigEn",     16'(DigEn),     16'(e_en));
    check("DigSel",    16'(DigSel),    16'(e_sel));
    check("Nibble",    16'(Nibble),    (m_act >> (4 * e_sel)) & 16'hF);
    check("Ack",       16'(Ack),       16'(e_ack));
    check("FrameTick", 16'(FrameTick), 16'(e_tick));
  endtask

  task automatic run_to_wrap_edge;
    while ((n % (4 * P)) != 4 * P - 1) step(1, 0, 0);
  endtask

  int acks;

  initial begin
    // reset held with Run=1
    for (int i = 0; i < 3; i++) step(1, 0, 16'hFFFF, 1);
    for (int i = 0; i < 70; i++) step(1, 0, 0);
    // basic load mid-frame
    step(1, 1, 16'hA5C3);
    for (int i = 0; i < 80; i++) step(1, 0, 0);
    check("active_A5C3", m_act, 16'hA5C3);
    // overwrite before the boundary: only one Ack
    run_to_wrap_edge();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 1, 16'h1234);
    step(1, 0, 0);
    step(1, 1, 16'h5678);
    acks = 0;
    for (int i = 0; i < 64; i++) begin step(1, 0, 0); acks += int'(Ack); end
    check("overwrite_acks", 16'(acks), 16'd1);
    // load on the boundary edge while another word is pending
    step(1, 1, 16'h0001);
    run_to_wrap_edge();
    step(1, 1, 16'hBEEF);
    check("bnd_ack1", 16'(Ack), 16'd1);
    for (int i = 0; i < 4 * P; i++) step(1, 0, 0);
    check("bnd_ack2", 16'(Ack), 16'd1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    // Run dropped mid-SHOW with a pending word
    step(1, 1, 16'h9876);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 0, 0);
    check("halt_ack", 16'(Ack), 16'd1);
    step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    // leading-zero cases
    step(0, 1, 16'h0042);
    for (int i = 0; i < 70; i++) step(1, 0, 0);
    step(0, 1, 16'h0000);
    for (int i = 0; i < 70; i++) step(1, 0, 0);
    // reset mid-operation discards a pending word
    step(1, 1, 16'h7777);
    step(1, 0, 0, 1);
    acks = 0;
    for (int i = 0; i < 40; i++) begin step(1, 0, 0); acks += int'(Ack); end
    check("discard_acks", 16'(acks), 16'd0);
    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0, 16'($urandom),
           $urandom_range(0, 299) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
